multi_timer: RTL and testbench

//   Parametrised N-channel down-counting timer; successor to the single 3-register timer.

---
 rtl/multi_timer_if.sv | 24 ++
 rtl/multi_timer.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_timer.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
// Bus bundle for multi_timer: address/write strobe/data from the CPU bridge,
// read data and interrupt lines back to it.
interface multi_timer_if #(
    parameter int unsigned NUM_CH = 4
) ();
    localparam int unsigned CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_AW+1:0]  ADDR;
    logic              WE;
    logic [31:0]       WD;
    logic [31:0]       RD;
    logic [NUM_CH-1:0] IRQ;
    logic              IRQ_ANY;

    modport master (
        output ADDR, WE, WD,
        input  RD, IRQ, IRQ_ANY
    );

    modport slave (
        input  ADDR, WE, WD,
        output RD, IRQ, IRQ_ANY
    );
endinterface

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent down-counting timers on a memory-mapped bus.
// Each channel: CTRL {IP[4], IM[3], MODE[1], EN[0]}, PRESET, COUNT and, when the
// TIMER_PRESCALE_EN macro is defined, a PSC register driving a per-channel
// prescaler (tick period PSC+1 clocks). Without the macro every clock is a tick.
// Address = {channel, reg}; reg 0 CTRL, 1 PRESET, 2 COUNT, 3 PSC.
module multi_timer #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PSC_W  = 8
) (
    input logic          CLK,
    input logic          RST_N,
    multi_timer_if.slave bus
);
    localparam int unsigned CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegPreset = 2'd1;
    localparam logic [1:0] RegCount  = 2'd2;
    localparam logic [1:0] RegPsc    = 2'd3;

    // Address decode
    logic [CH_AW-1:0] addr_ch;
    logic [1:0]       addr_reg;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_preset;
    logic [NUM_CH-1:0] wr_count;

    assign addr_ch  = bus.ADDR[CH_AW+1:2];
    assign addr_reg = bus.ADDR[1:0];

    // Per-channel state
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] im_q, im_d;
    logic [NUM_CH-1:0] ip_q, ip_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  preset_q [NUM_CH];
    logic [CNT_W-1:0]  preset_d [NUM_CH];

    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] expire;

    // Only the low bits of WD carry state; the rest is deliberately ignored.
    logic unused_wd;
    assign unused_wd = ^bus.WD;

    // Channel select and per-register write strobes; out-of-range channels match nothing
    always_comb begin
        sel       = '0;
        wr_ctrl   = '0;
        wr_preset = '0;
        wr_count  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i]       = (addr_ch == CH_AW'(i));
            wr_ctrl[i]   = bus.WE && sel[i] && (addr_reg == RegCtrl);
            wr_preset[i] = bus.WE && sel[i] && (addr_reg == RegPreset);
            wr_count[i]  = bus.WE && sel[i] && (addr_reg == RegCount);
        end
    end

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0]  psc_q  [NUM_CH];
    logic [PSC_W-1:0]  psc_d  [NUM_CH];
    logic [PSC_W-1:0]  pcnt_q [NUM_CH];
    logic [PSC_W-1:0]  pcnt_d [NUM_CH];
    logic [NUM_CH-1:0] wr_psc;

    // PSC write strobes and tick generation: tick on the clock where pcnt == PSC
    always_comb begin
        wr_psc = '0;
        tick   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_psc[i] = bus.WE && sel[i] && (addr_reg == RegPsc);
            tick[i]   = (pcnt_q[i] == psc_q[i]);
        end
    end

    // Prescale counter: runs while enabled, restarts on enable and on PSC write
    always_comb begin
        psc_d  = psc_q;
        pcnt_d = pcnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (en_q[i]) begin
                pcnt_d[i] = tick[i] ? '0 : pcnt_q[i] + PSC_W'(1);
            end
            if (wr_ctrl[i] && !en_q[i] && bus.WD[0]) begin
                pcnt_d[i] = '0;
            end
            if (wr_psc[i]) begin
                psc_d[i]  = bus.WD[PSC_W-1:0];
                pcnt_d[i] = '0;
            end
        end
    end

    // Prescaler registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                psc_q[i]  <= '0;
                pcnt_q[i] <= '0;
            end
        end else begin
            psc_q  <= psc_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    logic [PSC_W-1:0] unused_psc;
    assign unused_psc = '0;
    assign tick = '1;
`endif

    // A channel counts on a tick while enabled with a non-zero COUNT; 1 -> expiry
    always_comb begin
        active = '0;
        expire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active[i] = en_q[i] && (cnt_q[i] != '0) && tick[i];
            expire[i] = active[i] && (cnt_q[i] == CNT_W'(1));
        end
    end

    // Next-state: autonomous counting first, then bus writes override it
    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        ip_d     = ip_q;
        cnt_d    = cnt_q;
        preset_d = preset_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (active[i]) begin
                if (expire[i]) begin
                    ip_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        cnt_d[i] = preset_q[i];
                    end else begin
                        cnt_d[i] = '0;
                        en_d[i]  = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end

            if (wr_ctrl[i]) begin
                en_d[i]   = bus.WD[0];
                mode_d[i] = bus.WD[1];
                im_d[i]   = bus.WD[3];
                // W1C loses to a same-cycle expiry
                if (bus.WD[4] && !expire[i]) begin
                    ip_d[i] = 1'b0;
                end
                if (!en_q[i] && bus.WD[0]) begin
                    cnt_d[i] = preset_q[i];
                end
            end

            if (wr_preset[i]) begin
                preset_d[i] = bus.WD[CNT_W-1:0];
            end

            // A COUNT write cancels this cycle's tick entirely, including IP set and EN clear
            if (wr_count[i]) begin
                cnt_d[i] = bus.WD[CNT_W-1:0];
                en_d[i]  = en_q[i];
                ip_d[i]  = ip_q[i];
            end
        end
    end

    // Channel registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            en_q   <= '0;
            mode_q <= '0;
            im_q   <= '0;
            ip_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                preset_q[i] <= '0;
            end
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            ip_q     <= ip_d;
            cnt_q    <= cnt_d;
            preset_q <= preset_d;
        end
    end

    // Read mux; unselected or out-of-range addresses return zero
    logic [31:0] rd;
    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel[i]) begin
                unique case (addr_reg)
                    RegCtrl:   rd = {27'd0, ip_q[i], im_q[i], 1'b0, mode_q[i], en_q[i]};
                    RegPreset: rd[CNT_W-1:0] = preset_q[i];
                    RegCount:  rd[CNT_W-1:0] = cnt_q[i];
`ifdef TIMER_PRESCALE_EN
                    RegPsc:    rd[PSC_W-1:0] = psc_q[i];
`else
                    RegPsc:    rd = '0;
`endif
                    default:   rd = '0;
                endcase
            end
        end
    end

    assign bus.RD      = rd;
    assign bus.IRQ     = ip_q & im_q;
    assign bus.IRQ_ANY = |(ip_q & im_q);

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios with literal
// expectations plus randomized bus traffic, all checked every cycle against a
// behavioural per-channel model.
module tb_multi_timer;
    localparam int unsigned NCH = 5;
    localparam int unsigned CW  = 8;
    localparam int unsigned PW  = 4;
    localparam int unsigned AW  = 3;
    localparam logic [31:0] CMASK = 32'h0000_00FF;
    localparam logic [31:0] PMASK = 32'h0000_000F;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multi_timer_if #(.NUM_CH(NCH)) bus ();

    multi_timer #(
        .NUM_CH(NCH),
        .CNT_W (CW),
        .PSC_W (PW)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    bit          m_en   [NCH];
    bit          m_mode [NCH];
    bit          m_im   [NCH];
    bit          m_ip   [NCH];
    logic [31:0] m_pre  [NCH];
    logic [31:0] m_cnt  [NCH];
    logic [31:0] m_psc  [NCH];
    logic [31:0] m_pc   [NCH];

    always @(posedge clk) begin
        int          wch, wrg;
        logic [31:0] wd;
        bit          tk, fired, old_en, old_ip;
        wch = int'(bus.ADDR[AW+1:2]);
        wrg = int'(bus.ADDR[1:0]);
        wd  = bus.WD;
        if (!rst_n) begin
            m_valid = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_ip[c] = 0;
                m_pre[c] = 0; m_cnt[c] = 0; m_psc[c] = 0; m_pc[c] = 0;
            end
        end else if (m_valid) begin
            for (int c = 0; c < NCH; c++) begin
                old_en = m_en[c];
                old_ip = m_ip[c];
`ifdef TIMER_PRESCALE_EN
                tk = (m_pc[c] == m_psc[c]);
                if (m_en[c]) m_pc[c] = tk ? 0 : m_pc[c] + 1;
`else
                tk = 1'b1;
`endif
                fired = 1'b0;
                if (old_en && m_cnt[c] != 0 && tk) begin
                    if (m_cnt[c] == 1) begin
                        fired   = 1'b1;
                        m_ip[c] = 1'b1;
                        if (m_mode[c]) m_cnt[c] = m_pre[c];
                        else begin
                            m_cnt[c] = 0;
                            m_en[c]  = 1'b0;
                        end
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end
                if (bus.WE && wch == c) begin
                    case (wrg)
                        0: begin
                            m_en[c]   = wd[0];
                            m_mode[c] = wd[1];
                            m_im[c]   = wd[3];
                            if (wd[4] && !fired) m_ip[c] = 1'b0;
                            if (!old_en && wd[0]) begin
                                m_cnt[c] = m_pre[c];
                                m_pc[c]  = 0;
                            end
                        end
                        1: m_pre[c] = wd & CMASK;
                        2: begin
                            m_cnt[c] = wd & CMASK;
                            m_en[c]  = old_en;
                            m_ip[c]  = old_ip;
                        end
                        default: begin
`ifdef TIMER_PRESCALE_EN
                            m_psc[c] = wd & PMASK;
                            m_pc[c]  = 0;
`endif
                        end
                    endcase
                end
            end
        end
    end

    function automatic logic [31:0] mread(logic [AW+1:0] a);
        int c;
        c = int'(a[AW+1:2]);
        if (c >= NCH) return 32'd0;
        case (a[1:0])
            2'd0: return {27'd0, m_ip[c], m_im[c], 1'b0, m_mode[c], m_en[c]};
            2'd1: return m_pre[c];
            2'd2: return m_cnt[c];
`ifdef TIMER_PRESCALE_EN
            default: return m_psc[c];
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    function automatic logic [31:0] exp_irq();
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c] = m_ip[c] & m_im[c];
        return r;
    endfunction

    // Every-cycle comparison, mid-cycle
    always @(negedge clk) begin
        if (m_valid) begin
            chk($sformatf("rd@%0h", bus.ADDR), bus.RD, mread(bus.ADDR));
            chk("irq", 32'(bus.IRQ), exp_irq());
            chk("irq_any", 32'(bus.IRQ_ANY), {31'd0, |exp_irq()});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(int ch, int rg, logic [31:0] d);
        logic [AW-1:0] c;
        logic [1:0]    r;
        c = ch[AW-1:0];
        r = rg[1:0];
        bus.ADDR = {c, r};
        bus.WE   = 1'b1;
        bus.WD   = d;
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
        bus.WD = $urandom;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic adv(int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_rd(int ch, int rg, logic [31:0] e, string nm);
        logic [AW-1:0] c;
        logic [1:0]    r;
        c = ch[AW-1:0];
        r = rg[1:0];
        bus.ADDR = {c, r};
        #1;
        chk(nm, bus.RD, e);
    endtask

    task automatic chk_irq(logic [31:0] e, string nm);
        chk(nm, 32'(bus.IRQ), e);
        chk({nm, "_any"}, 32'(bus.IRQ_ANY), {31'd0, e != 0});
    endtask

    task automatic edges_to_irq(int b, int bound, output int n);
        n = 0;
        while (bus.IRQ[b] !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int ch, rg;
        rst_n    = 1'b0;
        bus.ADDR = '0;
        bus.WE   = 1'b0;
        bus.WD   = '0;
        adv(2);
        rst_n = 1'b1;
        chk_irq(0, "init_irq");
        chk_rd(0, 0, 0, "init_ctrl");

        // One-shot on ch0
        wr(0, 1, 5);
        wr(0, 0, 32'h9);
        settle();
        chk_rd(0, 2, 5, "os_cnt5");
        for (int k = 4; k >= 0; k--) begin
            adv(1);
            chk_rd(0, 2, k, "os_cnt");
        end
        chk_irq(32'h1, "os_irq");
        chk_rd(0, 0, 32'h18, "os_ctrl_en_cleared");
        wr(0, 0, 32'h10);
        settle();
        chk_irq(0, "os_w1c");
        chk_rd(0, 0, 0, "os_ctrl_after_w1c");

        // Periodic on ch2
        wr(2, 1, 3);
        wr(2, 0, 32'hB);
        settle();
        chk_irq(0, "per_start_irq");
        chk_rd(2, 2, 3, "per_load");
        adv(2);
        chk_rd(2, 2, 1, "per_cnt1");
        adv(1);
        chk_irq(32'h4, "per_first_irq");
        chk_rd(2, 2, 3, "per_reload");
        wr(2, 0, 32'h1B);
        settle();
        chk_irq(0, "per_w1c");
        adv(1);
        wr(2, 0, 32'h1B);
        settle();
        chk_irq(32'h4, "per_set_beats_w1c");
        wr(2, 1, 6);
        settle();
        chk_rd(2, 2, 2, "per_preset_no_effect");
        chk_rd(2, 1, 6, "per_preset_rd");
        wr(2, 0, 32'h1B);
        adv(1);
        chk_irq(32'h4, "per_irq_before_new_preset");
        chk_rd(2, 2, 6, "per_reload6");
        wr(2, 0, 32'h1B);
        adv(4);
        chk_rd(2, 2, 1, "per6_cnt1");
        adv(1);
        chk_irq(32'h4, "per6_irq");
        wr(2, 0, 32'h10);
        settle();
        chk_rd(2, 2, 5, "disable_keeps_cnt");
        adv(3);
        chk_rd(2, 2, 5, "frozen_cnt");

        // PRESET=0 holds, COUNT write of 1 fires next tick
        wr(1, 1, 0);
        wr(1, 0, 32'h9);
        adv(3);
        chk_rd(1, 2, 0, "zero_hold");
        chk_irq(0, "zero_no_irq");
        chk_rd(1, 0, 32'h9, "zero_en_stays");
        wr(1, 2, 1);
        settle();
        chk_rd(1, 2, 1, "cnt_wr1");
        chk_irq(0, "cnt_wr_no_ip");
        adv(1);
        chk_irq(32'h2, "cnt_wr_fire");
        wr(1, 0, 32'h10);

        // 8-bit counter: 255-tick period, upper read bits zero
        wr(4, 1, 32'h1FF);
        settle();
        chk_rd(4, 1, 32'hFF, "preset_trunc");
        wr(4, 0, 32'hB);
        edges_to_irq(4, 400, n);
        chk("period255", n, 255);
        chk_rd(4, 2, 32'hFF, "reload_ff");
        wr(4, 0, 32'h10);
        wr(4, 2, 32'hFFFF_AB12);
        settle();
        chk_rd(4, 2, 32'h12, "count_trunc");

        // ch1 and ch3 expire together
        wr(1, 1, 4);
        wr(3, 1, 3);
        wr(1, 0, 32'h9);
        wr(3, 0, 32'h9);
        adv(3);
        chk_irq(32'hA, "multi_irq");
        wr(1, 0, 32'h10);
        settle();
        chk_irq(32'h8, "multi_clear1");
        wr(3, 0, 32'h10);
        settle();
        chk_irq(0, "multi_clear3");

        // Out-of-range channels
        wr(6, 1, 32'h55);
        wr(7, 0, 32'h9);
        settle();
        chk_rd(6, 1, 0, "oor_preset");
        chk_rd(7, 0, 0, "oor_ctrl");
        chk_irq(0, "oor_irq");

        // Prescaler latency
        wr(0, 3, 3);
        wr(0, 1, 2);
        wr(0, 0, 32'h9);
        edges_to_irq(0, 100, n);
`ifdef TIMER_PRESCALE_EN
        chk("psc_latency", n, 8);
        chk_rd(0, 3, 3, "psc_rd");
`else
        chk("psc_latency", n, 2);
        chk_rd(0, 3, 0, "psc_rd_zero");
`endif
        wr(0, 0, 32'h10);

        // Reset mid-count
        wr(2, 1, 50);
        wr(2, 0, 32'hB);
        wr(4, 1, 7);
        wr(4, 0, 32'h9);
        adv(3);
        rst_n = 1'b0;
        adv(2);
        rst_n = 1'b1;
        chk_irq(0, "rst_irq");
        for (int a = 0; a < 32; a++) begin
            chk_rd(a >> 2, a & 3, 0, "rst_reg");
            adv(1);
        end

        // Randomized traffic, checked by the model every cycle
        @(posedge clk);
        #1;
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] c;
            logic [1:0]    r;
            rst_n = ($urandom_range(0, 799) != 0);
            ch = $urandom_range(0, 6);
            rg = $urandom_range(0, 3);
            c = ch[AW-1:0];
            r = rg[1:0];
            bus.ADDR = {c, r};
            bus.WE   = ($urandom_range(0, 3) == 0);
            case (rg)
                0: bus.WD = $urandom;
                1, 2: bus.WD = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 8);
                default: bus.WD = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 3);
            endcase
            @(posedge clk);
            #1;
        end
        rst_n  = 1'b1;
        bus.WE = 1'b0;
        adv(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
